// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the instruction ROM read port between fetch and debug.
// Fetch has priority; a denial counter forces a debug slot after MAX_WAIT denials.
module imem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WAIT   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_stall,
    input  logic                  dbg_req,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic                  dbg_gnt,
    output logic                  dbg_valid,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q
);
    typedef enum logic {FETCH_PRI, DBG_FORCE} state_t;
    localparam logic [3:0] LAST = 4'(MAX_WAIT - 1);
    state_t     state;
    logic [3:0] wait_cnt;
    assign dbg_gnt     = dbg_req & (state == DBG_FORCE | ~fetch_req);
    assign fetch_gnt   = fetch_req & ~dbg_gnt;
    assign fetch_stall = fetch_req & ~fetch_gnt;
    assign rom_addr    = dbg_gnt ? dbg_addr : fetch_addr;
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH_PRI;
            wait_cnt    <= '0;
            fetch_valid <= 1'b0;
            dbg_valid   <= 1'b0;
            fetch_data  <= '0;
            dbg_data    <= '0;
        end else begin
            fetch_valid <= fetch_gnt;
            dbg_valid   <= dbg_gnt;
            if (fetch_gnt) fetch_data <= rom_q;
            if (dbg_gnt) dbg_data <= rom_q;
            // a denied debug request only ever happens in FETCH_PRI
            if (dbg_req & ~dbg_gnt) begin
                wait_cnt <= (wait_cnt == LAST) ? wait_cnt : wait_cnt + 4'd1;
                if (wait_cnt == LAST) state <= DBG_FORCE;
            end else begin
                wait_cnt <= '0;
                state    <= FETCH_PRI;
            end
        end
    end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed and random checks of the arbiter against a
// model built on "debug wins after MAX_WAIT consecutive denials".
module tb_imem_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_req, dbg_req;
    logic [AW-1:0] fetch_addr, dbg_addr, rom_addr;
    logic          fetch_gnt, fetch_valid, fetch_stall, dbg_gnt, dbg_valid;
    logic [DW-1:0] fetch_data, dbg_data, rom_q;

    int checks = 0;
    int errors = 0;

    // reference model state
    int            denials = 0;
    logic          e_fv = 0, e_dv = 0;
    logic [DW-1:0] e_fd = 0, e_dd = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
        return {a, ~a, a ^ 8'h5A, a + 8'd3};
    endfunction

    assign rom_q = romf(rom_addr);

    imem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_stall(fetch_stall),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_valid(dbg_valid), .dbg_data(dbg_data),
        .rom_addr(rom_addr), .rom_q(rom_q)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock cycle: drive inputs, check grants, then check registered outputs
    task automatic step(input logic r, input logic fr, input logic [AW-1:0] fa,
                        input logic dr, input logic [AW-1:0] da);
        logic dg, fg;
        reset = r; fetch_req = fr; fetch_addr = fa; dbg_req = dr; dbg_addr = da;
        #1;
        dg = dr & (!fr | denials >= MW);
        fg = fr & !dg;
        if (!r) begin
            chk("fetch_gnt", 32'(fetch_gnt), 32'(fg));
            chk("dbg_gnt", 32'(dbg_gnt), 32'(dg));
            chk("fetch_stall", 32'(fetch_stall), 32'(fr & !fg));
            if (fg | dg) chk("rom_addr", 32'(rom_addr), 32'(dg ? da : fa));
        end
        @(posedge clk);
        if (r) begin
            e_fv = 0; e_dv = 0; e_fd = 0; e_dd = 0; denials = 0;
        end else begin
            e_fv = fg;
            e_dv = dg;
            if (fg) e_fd = romf(fa);
            if (dg) e_dd = romf(da);
            denials = (dr & !dg) ? denials + 1 : 0;
        end
        #1;
        chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
        chk("fetch_data", fetch_data, e_fd);
        chk("dbg_valid", 32'(dbg_valid), 32'(e_dv));
        chk("dbg_data", dbg_data, e_dd);
    endtask

    initial begin
        logic [AW-1:0] pa;
        // reset with both requests high
        step(1, 1, 8'h00, 1, 8'h01);
        step(1, 1, 8'h00, 1, 8'h01);
        step(0, 1, 8'h20, 0, 8'h00);
        // fetch-only streaming
        for (int i = 0; i < 4; i++) step(0, 1, 8'(i), 0, 8'h00);
        // debug-only read
        step(0, 0, 8'h00, 1, 8'h10);
        step(0, 0, 8'h00, 0, 8'h00);
        // sustained contention: 3 fetch grants then 1 debug grant, repeating
        for (int i = 0; i < 12; i++) step(0, 1, 8'(8'h40 + i), 1, 8'h77);
        // debug drops while forced
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h50 + i), 1, 8'h88);
        step(0, 1, 8'h53, 0, 8'h88);
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h60 + i), 1, 8'h99);
        // reset the cycle after a debug grant
        step(0, 0, 8'h00, 1, 8'h33);
        step(1, 1, 8'h01, 1, 8'h34);
        step(0, 1, 8'h02, 1, 8'h34);
        // address wrap
        step(0, 1, 8'hFF, 0, 8'h00);
        step(0, 0, 8'h00, 1, 8'hFF);
        // random traffic; debug holds its address while pending
        pa = 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            logic dr;
            dr = ($urandom_range(3) != 0);
            step(($urandom_range(40) == 0), ($urandom_range(3) != 0), 8'($urandom), dr, pa);
            if (dbg_valid | !dr) pa = 8'($urandom);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
